// File: rtl/dev_bus_arb_pkg.sv
// Shared definitions for the two-master device-bus arbiter:
// FSM state encoding, master IDs, one-hot grant codes and the
// load-data pattern returned on a watchdog expiry.
package dev_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic MASTER0 = 1'b0;
    localparam logic MASTER1 = 1'b1;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational two-way picker: turns the request pair into a one-hot
// next grant. On a tie, FIXED_PRIO!=0 always favours master 0; otherwise
// the master that did not own the bus last (rr_last) wins.
module arb_rr_picker #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] grant
);
    import dev_bus_arb_pkg::*;

    // Tie-break selection between the two requesters
    always_comb begin
        grant = GRANT_NONE;
        case (req)
            2'b01:   grant = GRANT_M0;
            2'b10:   grant = GRANT_M1;
            2'b11: begin
                if (FIXED_PRIO != 0 || rr_last == MASTER1) grant = GRANT_M0;
                else                                       grant = GRANT_M1;
            end
            default: grant = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Two-master arbiter in front of the device-bus decoder. One master owns
// the bus per transaction; the grant is released on completion
// (enable & ~devBusy_i) or when the owner drops its enable.
// Optional watchdog: define ARB_WATCHDOG_EN to abort transactions that
// stay busy for TIMEOUT cycles and raise the sticky timeout_o flag.
module dev_bus_arbiter #(
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0Enable_i,
    input  logic        m0Write_i,
    input  logic [31:0] m0Addr_i,
    input  logic [31:0] m0DataSave_i,
    input  logic [3:0]  m0ByteSelect_i,
    output logic [31:0] m0DataLoad_o,
    output logic        m0Busy_o,
    input  logic        m1Enable_i,
    input  logic        m1Write_i,
    input  logic [31:0] m1Addr_i,
    input  logic [31:0] m1DataSave_i,
    input  logic [3:0]  m1ByteSelect_i,
    output logic [31:0] m1DataLoad_o,
    output logic        m1Busy_o,
    output logic        devEnable_o,
    output logic        devWrite_o,
    output logic [31:0] devPhysicalAddr_o,
    output logic [31:0] devDataSave_o,
    output logic [3:0]  devByteSelect_o,
    input  logic [31:0] devDataLoad_i,
    input  logic        devBusy_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);
    import dev_bus_arb_pkg::*;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("dev_bus_arbiter: TIMEOUT must be at least 2");
    end

    arb_state_t state, state_next;
    logic       rr_last, rr_last_next;
    logic [1:0] req;
    logic [1:0] pick;
    logic       wd_hit;
    logic       to_pulse;
    logic       to_master;

`ifdef ARB_WATCHDOG_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] hold_cnt;
    logic        timeout_flag;

    assign wd_hit = devBusy_i && (hold_cnt == WD_LIMIT) &&
                    ((state == ST_OWN0 && m0Enable_i) ||
                     (state == ST_OWN1 && m1Enable_i));

    // Hold counter, one-cycle expiry response and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt     <= '0;
            to_pulse     <= 1'b0;
            to_master    <= MASTER0;
            timeout_flag <= 1'b0;
        end else begin
            hold_cnt <= (state == ST_IDLE) ? '0 : hold_cnt + 16'd1;
            to_pulse <= wd_hit;
            if (wd_hit) begin
                to_master    <= (state == ST_OWN1);
                timeout_flag <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_flag;
`else
    assign wd_hit    = 1'b0;
    assign to_pulse  = 1'b0;
    assign to_master = MASTER0;
    assign timeout_o = 1'b0;
`endif

    // The expiry cycle acts as the timed-out master's completion, so its
    // still-asserted enable must not win a fresh grant in that same cycle.
    assign req = {m1Enable_i & ~(to_pulse & (to_master == MASTER1)),
                  m0Enable_i & ~(to_pulse & (to_master == MASTER0))};

    arb_rr_picker #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_picker (
        .req     (req),
        .rr_last (rr_last),
        .grant   (pick)
    );

    // State and round-robin history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rr_last <= MASTER1;
        end else begin
            state   <= state_next;
            rr_last <= rr_last_next;
        end
    end

    // Next-state selection and bus/response muxing for the grant holder
    always_comb begin
        state_next        = state;
        rr_last_next      = rr_last;
        grant_o           = GRANT_NONE;
        devEnable_o       = 1'b0;
        devWrite_o        = 1'b0;
        devPhysicalAddr_o = '0;
        devDataSave_o     = '0;
        devByteSelect_o   = '0;
        m0Busy_o          = m0Enable_i;
        m1Busy_o          = m1Enable_i;
        m0DataLoad_o      = '0;
        m1DataLoad_o      = '0;
        case (state)
            ST_IDLE: begin
                if (pick[0])      state_next = ST_OWN0;
                else if (pick[1]) state_next = ST_OWN1;
                if (to_pulse) begin
                    if (to_master == MASTER0) begin
                        m0Busy_o     = 1'b0;
                        m0DataLoad_o = TIMEOUT_DATA;
                    end else begin
                        m1Busy_o     = 1'b0;
                        m1DataLoad_o = TIMEOUT_DATA;
                    end
                end
            end
            ST_OWN0: begin
                grant_o           = GRANT_M0;
                devEnable_o       = m0Enable_i;
                devWrite_o        = m0Write_i;
                devPhysicalAddr_o = m0Addr_i;
                devDataSave_o     = m0DataSave_i;
                devByteSelect_o   = m0ByteSelect_i;
                m0Busy_o          = devBusy_i;
                m0DataLoad_o      = devDataLoad_i;
                if (!m0Enable_i || !devBusy_i || wd_hit) begin
                    state_next   = ST_IDLE;
                    rr_last_next = MASTER0;
                end
            end
            ST_OWN1: begin
                grant_o           = GRANT_M1;
                devEnable_o       = m1Enable_i;
                devWrite_o        = m1Write_i;
                devPhysicalAddr_o = m1Addr_i;
                devDataSave_o     = m1DataSave_i;
                devByteSelect_o   = m1ByteSelect_i;
                m1Busy_o          = devBusy_i;
                m1DataLoad_o      = devDataLoad_i;
                if (!m1Enable_i || !devBusy_i || wd_hit) begin
                    state_next   = ST_IDLE;
                    rr_last_next = MASTER1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
